toll_lane_scheduler: RTL and testbench

// - Parametrised successor to the fixed 6-lane toll allocator: assigns each arriving vehicle to the least-loaded eligible lane.
// - Keeps per-lane queue counts and models per-lane service time by vehicle type, so lanes drain on their own (no external feedback loop).
// - Sits between the vehicle-detect front end and the toll/balance logic; asg_* outputs drive the lane signage and billing.

---
 rtl/toll_pkg.sv | 32 +++
 rtl/toll_lane_server.sv | 103 ++++++++++
 rtl/toll_lane_scheduler.sv | 106 ++++++++++
 tb/tb_toll_lane_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/toll_pkg.sv
// Shared definitions for the toll lane scheduler.
// - vh_type_t   : 2-bit vehicle type code carried on arr_vhType and in lane FIFOs
// - srv_state_t : per-lane server FSM states
// - svc_cycles  : service time of a vehicle type, given the three configured times
package toll_pkg;

    typedef enum logic [1:0] {
        VH_BIKE  = 2'b00,
        VH_CAR   = 2'b01,
        VH_TRUCK = 2'b10,
        VH_INV   = 2'b11
    } vh_type_t;

    typedef enum logic {
        SRV_IDLE    = 1'b0,
        SRV_SERVING = 1'b1
    } srv_state_t;

    // VH_INV never reaches a lane; it falls into the truck arm only to keep
    // the function total.
    function automatic int unsigned svc_cycles(input logic [1:0] vh,
                                               input int unsigned svc_bike,
                                               input int unsigned svc_car,
                                               input int unsigned svc_truck);
        case (vh)
            VH_BIKE: return svc_bike;
            VH_CAR:  return svc_car;
            default: return svc_truck;
        endcase
    endfunction

endpackage

// File: rtl/toll_lane_server.sv
// One toll lane: type FIFO, vehicle count and service-time model.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   enable         0 freezes timer, FSM, count and FIFO
//   push/push_type enqueue one vehicle of the given type (caller guarantees !full)
//   count          vehicles currently in the lane (head included)
//   full           count == 2**CNT_W-1
//   served         1-cycle pulse, registered: the head vehicle left at the last edge
module toll_lane_server
    import toll_pkg::*;
#(
    parameter int CNT_W     = 3,
    parameter int TIMER_W   = 4,
    parameter int SVC_BIKE  = 2,
    parameter int SVC_CAR   = 3,
    parameter int SVC_TRUCK = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             push,
    input  logic [1:0]       push_type,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             served
);
    localparam int MAX_Q = 2**CNT_W - 1;

    logic [1:0]         fifo [MAX_Q];
    logic [CNT_W-1:0]   rd_ptr, wr_ptr;
    logic [TIMER_W-1:0] timer_q, timer_d;
    srv_state_t         state_q, state_d;
    logic               pop, do_push;
    logic [1:0]         next_head;

    function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
        return (p == CNT_W'(MAX_Q - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [TIMER_W-1:0] svc_load(input logic [1:0] vh);
        return TIMER_W'(svc_cycles(vh, SVC_BIKE, SVC_CAR, SVC_TRUCK) - 1);
    endfunction

    assign do_push = push & enable;
    assign full    = (count == CNT_W'(MAX_Q));

    // Vehicle behind the departing head; with a single vehicle queued it can
    // only be one arriving on this very edge.
    assign next_head = (count > CNT_W'(1)) ? fifo[ptr_inc(rd_ptr)] : push_type;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pop     = 1'b0;
        case (state_q)
            SRV_IDLE: begin
                if (count != '0) begin
                    state_d = SRV_SERVING;
                    timer_d = svc_load(fifo[rd_ptr]);
                end
            end
            SRV_SERVING: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    pop = 1'b1;
                    if (count > CNT_W'(1) || do_push)
                        timer_d = svc_load(next_head);
                    else
                        state_d = SRV_IDLE;
                end
            end
            default: state_d = SRV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SRV_IDLE;
            timer_q <= '0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            served  <= 1'b0;
        end else if (enable) begin
            state_q <= state_d;
            timer_q <= timer_d;
            count   <= count + CNT_W'(do_push) - CNT_W'(pop);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            served  <= pop;
        end else begin
            served  <= 1'b0;
        end
    end

    // Payload storage needs no reset: entries are only read below count.
    always_ff @(posedge clk) begin
        if (!reset && do_push)
            fifo[wr_ptr] <= push_type;
    end

endmodule

// File: rtl/toll_lane_scheduler.sv
// Assigns each arriving vehicle to the least-loaded eligible lane and models
// per-lane service so lanes drain on their own.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   enable                     0: no accepts, all lane state frozen
//   arr_valid/arr_ready        arrival handshake; arr_ready = enable
//   arr_priority, arr_vhType   arrival attributes (vhType 11 = invalid)
//   asg_valid/asg_lane         registered assignment, one cycle after accept
//   asg_reject                 registered refusal pulse
//   lane_count, lane_full      per-lane occupancy, lane i at [i*CNT_W +: CNT_W]
//   served_pulse               per-lane departure pulse
module toll_lane_scheduler
    import toll_pkg::*;
#(
    parameter int NUM_LANES  = 6,
    parameter int PRIO_LANES = 1,
    parameter int CNT_W      = 3,
    parameter int TIMER_W    = 4,
    parameter int SVC_BIKE   = 2,
    parameter int SVC_CAR    = 3,
    parameter int SVC_TRUCK  = 5,
    localparam int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       arr_valid,
    output logic                       arr_ready,
    input  logic                       arr_priority,
    input  logic [1:0]                 arr_vhType,
    output logic                       asg_valid,
    output logic [LANE_W-1:0]          asg_lane,
    output logic                       asg_reject,
    output logic [NUM_LANES*CNT_W-1:0] lane_count,
    output logic [NUM_LANES-1:0]       lane_full,
    output logic [NUM_LANES-1:0]       served_pulse
);
    logic [NUM_LANES-1:0][CNT_W-1:0] cnt;
    logic [NUM_LANES-1:0]            prio_ok, gen_ok, elig, push;
    logic [LANE_W-1:0]               best;
    logic [CNT_W-1:0]                best_cnt;
    logic                            found, accept, do_asg, do_rej;

    assign arr_ready = enable;
    assign accept    = arr_valid & enable;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        toll_lane_server #(
            .CNT_W    (CNT_W),
            .TIMER_W  (TIMER_W),
            .SVC_BIKE (SVC_BIKE),
            .SVC_CAR  (SVC_CAR),
            .SVC_TRUCK(SVC_TRUCK)
        ) u_srv (
            .clk      (clk),
            .reset    (reset),
            .enable   (enable),
            .push     (push[g]),
            .push_type(arr_vhType),
            .count    (cnt[g]),
            .full     (lane_full[g]),
            .served   (served_pulse[g])
        );
        assign lane_count[g*CNT_W +: CNT_W] = cnt[g];
    end

    // Full is judged on pre-edge counts, so a lane at capacity that departs
    // on this edge is still skipped and counts cannot wrap.
    always_comb begin
        prio_ok  = '0;
        gen_ok   = '0;
        found    = 1'b0;
        best     = '0;
        best_cnt = '1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (i < PRIO_LANES) prio_ok[i] = !lane_full[i];
            else                gen_ok[i]  = !lane_full[i];
        end
        elig = (arr_priority && |prio_ok) ? prio_ok : gen_ok;
        // Strict < keeps the lowest index on ties.
        for (int i = 0; i < NUM_LANES; i++) begin
            if (elig[i] && (!found || cnt[i] < best_cnt)) begin
                found    = 1'b1;
                best     = LANE_W'(i);
                best_cnt = cnt[i];
            end
        end
        do_rej = accept && (arr_vhType == VH_INV || !found);
        do_asg = accept && !do_rej;
        for (int i = 0; i < NUM_LANES; i++)
            push[i] = do_asg && (best == LANE_W'(i));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            asg_valid  <= 1'b0;
            asg_reject <= 1'b0;
            asg_lane   <= '0;
        end else begin
            asg_valid  <= do_asg;
            asg_reject <= do_rej;
            if (do_asg) asg_lane <= best;
        end
    end

endmodule

// File: tb/tb_toll_lane_scheduler.sv
module tb_toll_lane_scheduler;
    localparam int NL = 6, PL = 1, CW = 3, TW = 4;
    localparam int SB = 2, SC = 3, ST = 16;
    localparam int LW = $clog2(NL);
    localparam int MAXQ = 7;

    logic            clk = 1'b0;
    logic            reset = 1'b1, enable = 1'b0;
    logic            arr_valid = 1'b0, arr_priority = 1'b0;
    logic [1:0]      arr_vhType = 2'd0;
    logic            arr_ready, asg_valid, asg_reject;
    logic [LW-1:0]   asg_lane;
    logic [NL*CW-1:0] lane_count;
    logic [NL-1:0]   lane_full, served_pulse;

    always #5 clk = ~clk;

    toll_lane_scheduler #(
        .NUM_LANES(NL), .PRIO_LANES(PL), .CNT_W(CW), .TIMER_W(TW),
        .SVC_BIKE(SB), .SVC_CAR(SC), .SVC_TRUCK(ST)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .arr_valid(arr_valid), .arr_ready(arr_ready),
        .arr_priority(arr_priority), .arr_vhType(arr_vhType),
        .asg_valid(asg_valid), .asg_lane(asg_lane), .asg_reject(asg_reject),
        .lane_count(lane_count), .lane_full(lane_full), .served_pulse(served_pulse)
    );

    int checks = 0, errors = 0;
    bit chk_on = 0;

    task automatic check(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp_v, $time);
        end
    endtask

    // Model: each lane is a list of vehicle types plus "edges left until the
    // head departs" (-1 when nobody is in service).
    int mty [NL][8];
    int msz [NL];
    int mrem[NL];
    bit mpop[NL];
    int pick;
    bit m_av, m_rj;
    int m_lane;
    bit [NL-1:0] m_srv;

    function automatic int svc(input int t);
        return (t == 0) ? SB : (t == 1) ? SC : ST;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NL; i++) begin msz[i] = 0; mrem[i] = -1; end
            m_av = 0; m_rj = 0; m_lane = 0; m_srv = '0;
        end else if (!enable) begin
            m_av = 0; m_rj = 0; m_srv = '0;
        end else begin
            pick = -1;
            if (arr_valid && arr_vhType != 2'd3) begin
                if (arr_priority)
                    for (int i = 0; i < PL; i++)
                        if (msz[i] < MAXQ && (pick < 0 || msz[i] < msz[pick])) pick = i;
                if (pick < 0)
                    for (int i = PL; i < NL; i++)
                        if (msz[i] < MAXQ && (pick < 0 || msz[i] < msz[pick])) pick = i;
            end
            m_av = arr_valid && pick >= 0;
            m_rj = arr_valid && pick < 0;
            if (m_av) m_lane = pick;
            for (int i = 0; i < NL; i++) begin
                mpop[i] = 0;
                if (mrem[i] < 0) begin
                    if (msz[i] > 0) mrem[i] = svc(mty[i][0]);
                end else if (mrem[i] == 1) mpop[i] = 1;
                else mrem[i]--;
            end
            for (int i = 0; i < NL; i++) begin
                if (mpop[i]) begin
                    for (int j = 0; j < 7; j++) mty[i][j] = mty[i][j+1];
                    msz[i]--;
                end
                if (pick == i) begin mty[i][msz[i]] = int'(arr_vhType); msz[i]++; end
                if (mpop[i]) mrem[i] = (msz[i] > 0) ? svc(mty[i][0]) : -1;
                m_srv[i] = mpop[i];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("arr_ready", int'(arr_ready), int'(enable));
            check("asg_valid", int'(asg_valid), int'(m_av));
            check("asg_reject", int'(asg_reject), int'(m_rj));
            check("asg_lane", int'(asg_lane), m_lane);
            for (int i = 0; i < NL; i++) begin
                check($sformatf("lane_count[%0d]", i), int'(lane_count[i*CW +: CW]), msz[i]);
                check($sformatf("lane_full[%0d]", i), int'(lane_full[i]), int'(msz[i] == MAXQ));
                check($sformatf("served_pulse[%0d]", i), int'(served_pulse[i]), int'(m_srv[i]));
            end
        end
    end

    task automatic drive(input bit v, input bit pri, input int ty);
        arr_valid = v; arr_priority = pri; arr_vhType = 2'(ty);
        @(posedge clk); #2;
        arr_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1; drive(0, 0, 0); reset = 0;
    endtask

    function automatic bit gen_full();
        for (int i = PL; i < NL; i++) if (msz[i] != MAXQ) return 0;
        return 1;
    endfunction

    initial begin
        drive(0, 0, 0); drive(0, 0, 0);
        chk_on = 1;
        reset = 0;
        // 1: reset state after idle cycles
        repeat (3) drive(0, 0, 0);
        check("rst_counts", int'(lane_count), 0);
        check("rst_full", int'(lane_full), 0);
        check("rst_asg", int'({asg_valid, asg_reject, asg_lane}), 0);
        check("rst_served", int'(served_pulse), 0);

        // 2: common cars spread over general lanes
        enable = 1;
        drive(1, 0, 1);
        check("car1_valid", int'(asg_valid), 1);
        check("car1_lane", int'(asg_lane), 1);
        drive(1, 0, 1);
        check("car2_lane", int'(asg_lane), 2);

        // 3: priority trucks stay on the non-full priority lane
        drive(1, 1, 2);
        check("prio1_lane", int'(asg_lane), 0);
        drive(1, 1, 2);
        check("prio2_lane", int'(asg_lane), 0);
        check("prio2_cnt0", int'(lane_count[0 +: CW]), 2);

        // 4: car into empty lane 3 departs at edge E+4
        do_reset();
        drive(1, 0, 1); drive(1, 0, 1);
        drive(1, 0, 1);                      // edge E
        check("car3_lane", int'(asg_lane), 3);
        repeat (3) drive(0, 0, 0);           // E+1..E+3
        check("l3_cnt_before", int'(lane_count[3*CW +: CW]), 1);
        check("l3_srv_before", int'(served_pulse[3]), 0);
        drive(0, 0, 0);                      // E+4
        check("l3_served", int'(served_pulse[3]), 1);
        check("l3_cnt_after", int'(lane_count[3*CW +: CW]), 0);

        // 5: invalid type, then saturate the general lanes
        do_reset();
        drive(1, 0, 3);
        check("inv_reject", int'(asg_reject), 1);
        check("inv_valid", int'(asg_valid), 0);
        for (int k = 0; k < 300 && !gen_full(); k++) drive(1, 0, 2);
        check("fill_reached", int'(gen_full()), 1);
        drive(1, 0, 0);
        check("full_reject", int'(asg_reject), 1);
        drive(1, 1, 0);
        check("full_prio_lane", int'(asg_lane), 0);

        // 6: freeze mid-service, then reset while serving
        do_reset();
        drive(1, 0, 1);
        drive(0, 0, 0); drive(0, 0, 0);
        enable = 0;
        repeat (10) drive(1, 0, 1);
        check("frz_cnt1", int'(lane_count[1*CW +: CW]), 1);
        check("frz_valid", int'(asg_valid), 0);
        enable = 1;
        drive(0, 0, 0);
        reset = 1;
        drive(1, 0, 1);
        reset = 0;
        check("rst_mid_counts", int'(lane_count), 0);
        check("rst_mid_asg", int'({asg_valid, asg_reject, asg_lane}), 0);
        check("rst_mid_served", int'(served_pulse), 0);
        repeat (8) drive(0, 0, 0);

        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
